// File: rtl/game_pkg.sv
// Shared types and defaults for the endless-runner game sequencer:
// FSM encoding, playfield geometry, speed limits and BCD score width.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    localparam int SPAWN_X_DEF    = 550;
    localparam int DESPAWN_X_DEF  = 10;
    localparam int SPEED_INIT_DEF = 1;
    localparam int SPEED_MAX_DEF  = 6;
    localparam int SCORE_DIV_DEF  = 6;

    localparam int X_W     = 10;
    localparam int SPEED_W = 3;
    localparam int SCORE_W = 16;

    // Packed BCD with equal digit counts orders the same as plain binary.
    function automatic logic bcd_gt(input logic [SCORE_W-1:0] a, input logic [SCORE_W-1:0] b);
        return a > b;
    endfunction

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit packed-BCD up-counter with synchronous clear, saturation at 9999
// and a flag telling whether the next increment rolls into the hundreds digit.
module bcd_counter4
    import game_pkg::*;
(
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_clr,
    input  logic               i_inc,
    output logic [SCORE_W-1:0] o_count,
    output logic               o_hund_carry
);

    logic [SCORE_W-1:0] r_count;
    logic [SCORE_W-1:0] w_count_inc;
    logic [4:0]         w_carry;
    logic               w_sat;

    assign w_carry[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            logic [3:0] w_digit;
            assign w_digit = r_count[gi*4 +: 4];
            assign w_count_inc[gi*4 +: 4] = !w_carry[gi]       ? w_digit :
                                            (w_digit == 4'd9)  ? 4'd0    : w_digit + 4'd1;
            assign w_carry[gi+1] = w_carry[gi] & (w_digit == 4'd9);
        end
    endgenerate

    // A carry out of every digit means the count is 9999.
    assign w_sat        = w_carry[4];
    assign o_hund_carry = w_carry[2] & ~w_sat;
    assign o_count      = r_count;

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && !w_sat) begin
            r_count <= w_count_inc;
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// Game-flow sequencer: IDLE/RUN/OVER control, obstacle scrolling, speed ramp,
// BCD score with high-score capture. Everything advances on one pulse per video frame.
module game_sequencer
    import game_pkg::*;
#(
    parameter int SPAWN_X    = SPAWN_X_DEF,
    parameter int DESPAWN_X  = DESPAWN_X_DEF,
    parameter int SPEED_INIT = SPEED_INIT_DEF,
    parameter int SPEED_MAX  = SPEED_MAX_DEF,
    parameter int SCORE_DIV  = SCORE_DIV_DEF
)(
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               start,
    input  logic               collision,
    output logic [1:0]         state,
    output logic [X_W-1:0]     cacti_x,
    output logic [SPEED_W-1:0] speed,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] hi_score,
    output logic               game_over
);

    localparam int DIV_W = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;
    localparam logic [X_W-1:0]     SPAWN_V   = X_W'(SPAWN_X);
    localparam logic [X_W:0]       DESPAWN_V = (X_W+1)'(DESPAWN_X);
    localparam logic [SPEED_W-1:0] INIT_V    = SPEED_W'(SPEED_INIT);
    localparam logic [SPEED_W-1:0] MAX_V     = SPEED_W'(SPEED_MAX);
    localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(SCORE_DIV - 1);

    state_t               r_state, w_state_next;
    logic                 r_armed, r_start_d, r_tick_d, r_frame_pulse;
    logic [X_W-1:0]       r_cacti_x;
    logic [SPEED_W-1:0]   r_speed;
    logic [DIV_W-1:0]     r_div;
    logic [SCORE_W-1:0]   r_hi_score;
    logic                 r_game_over;
    logic                 w_start_pulse, w_restart, w_step, w_div_wrap;
    logic [SCORE_W-1:0]   w_score;
    logic                 w_hund_carry;
    logic [X_W:0]         w_limit;

    // r_armed blanks edge detection for the first cycle after reset, so a
    // button or tick already high at release is absorbed rather than seen as a rise.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_armed       <= 1'b0;
            r_start_d     <= 1'b0;
            r_tick_d      <= 1'b0;
            r_frame_pulse <= 1'b0;
        end else begin
            r_armed       <= 1'b1;
            r_start_d     <= start;
            r_tick_d      <= frame_tick;
            r_frame_pulse <= frame_tick & ~r_tick_d & r_armed;
        end
    end

    assign w_start_pulse = start & ~r_start_d & r_armed;

    always_ff @(posedge clk) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_start_pulse) w_state_next = ST_RUN;
            ST_RUN:  if (collision)     w_state_next = ST_OVER;
            ST_OVER: if (w_start_pulse) w_state_next = ST_RUN;
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_restart  = w_start_pulse && (r_state != ST_RUN);
    assign w_step     = (r_state == ST_RUN) && r_frame_pulse && !collision;
    assign w_div_wrap = w_step && (r_div == DIV_LAST);
    // Respawn once the obstacle would land on or past the left limit.
    assign w_limit    = DESPAWN_V + (X_W+1)'(r_speed);

    bcd_counter4 u_score (
        .clk          (clk),
        .i_rst_n      (reset),
        .i_clr        (w_restart),
        .i_inc        (w_div_wrap),
        .o_count      (w_score),
        .o_hund_carry (w_hund_carry)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cacti_x   <= SPAWN_V;
            r_speed     <= INIT_V;
            r_div       <= '0;
            r_hi_score  <= '0;
            r_game_over <= 1'b0;
        end else begin
            r_game_over <= (w_state_next == ST_OVER);
            if (w_restart) begin
                r_cacti_x <= SPAWN_V;
                r_speed   <= INIT_V;
                r_div     <= '0;
            end else if (w_step) begin
                if ((X_W+1)'(r_cacti_x) <= w_limit) r_cacti_x <= SPAWN_V;
                else                                r_cacti_x <= r_cacti_x - X_W'(r_speed);
                r_div <= (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
                if (w_div_wrap && w_hund_carry && (r_speed < MAX_V))
                    r_speed <= r_speed + SPEED_W'(1);
            end
            if ((r_state == ST_RUN) && collision && bcd_gt(w_score, r_hi_score))
                r_hi_score <= w_score;
        end
    end

    assign state     = r_state;
    assign cacti_x   = r_cacti_x;
    assign speed     = r_speed;
    assign score     = w_score;
    assign hi_score  = r_hi_score;
    assign game_over = r_game_over;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: a per-cycle vector table for control and
// edge-detect behaviour, then long hand-written runs for respawn, speed ramp and score saturation.
module tb_game_sequencer;
    import game_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0, frame_tick = 1'b0, start = 1'b0, start2 = 1'b0, collision = 1'b0;

    logic [1:0]  state1, state2;
    logic [9:0]  x1, x2;
    logic [2:0]  spd1, spd2;
    logic [15:0] sc1, sc2, hi1, hi2;
    logic        go1, go2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    game_sequencer dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start), .collision(collision),
        .state(state1), .cacti_x(x1), .speed(spd1), .score(sc1), .hi_score(hi1), .game_over(go1)
    );

    // Scores every frame so the speed cap and 9999 saturation are reachable quickly.
    game_sequencer #(.SCORE_DIV(1)) dut_fast (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start2), .collision(collision),
        .state(state2), .cacti_x(x2), .speed(spd2), .score(sc2), .hi_score(hi2), .game_over(go2)
    );

    typedef struct {
        logic        rst, st, tk, co;
        logic [1:0]  e_state;
        logic [9:0]  e_x;
        logic [15:0] e_score;
        logic        e_go;
    } vec_t;

    vec_t tbl [0:26];

    function automatic vec_t v(input logic rst, input logic st, input logic tk, input logic co,
                               input logic [1:0] s, input logic [9:0] x, input logic [15:0] sc,
                               input logic go);
        vec_t r;
        r.rst = rst; r.st = st; r.tk = tk; r.co = co;
        r.e_state = s; r.e_x = x; r.e_score = sc; r.e_go = go;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic [1:0] s, input logic [9:0] x,
                        input logic [2:0] sp, input logic [15:0] sc, input logic [15:0] hi,
                        input logic go);
        chk({tag, ".state"}, 32'(state1), 32'(s));
        chk({tag, ".cacti_x"}, 32'(x1), 32'(x));
        chk({tag, ".speed"}, 32'(spd1), 32'(sp));
        chk({tag, ".score"}, 32'(sc1), 32'(sc));
        chk({tag, ".hi_score"}, 32'(hi1), 32'(hi));
        chk({tag, ".game_over"}, 32'(go1), 32'(go));
        $display("%s: state=%0d x=%0d speed=%0d score=%h hi=%h go=%0d",
                 tag, state1, x1, spd1, sc1, hi1, go1);
    endtask

    task automatic chk2(input string tag, input logic [2:0] sp, input logic [15:0] sc);
        chk({tag, ".state"}, 32'(state2), 32'(ST_RUN));
        chk({tag, ".speed"}, 32'(spd2), 32'(sp));
        chk({tag, ".score"}, 32'(sc2), 32'(sc));
        $display("%s: state=%0d speed=%0d score=%h", tag, state2, spd2, sc2);
    endtask

    // One frame: tick rise is registered into a pulse, which acts on the next edge.
    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            @(posedge clk); #1;
            frame_tick = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        //            rst st tk co   state  x    score    go
        tbl[0]  = v(0, 0, 0, 0,   2'd0, 550, 16'h0000, 0);
        tbl[1]  = v(1, 0, 0, 0,   2'd0, 550, 16'h0000, 0);
        tbl[2]  = v(1, 1, 0, 0,   2'd1, 550, 16'h0000, 0);
        tbl[3]  = v(1, 1, 1, 0,   2'd1, 550, 16'h0000, 0);
        tbl[4]  = v(1, 0, 0, 0,   2'd1, 549, 16'h0000, 0);
        tbl[5]  = v(1, 0, 1, 0,   2'd1, 549, 16'h0000, 0);
        tbl[6]  = v(1, 0, 1, 0,   2'd1, 548, 16'h0000, 0);
        tbl[7]  = v(1, 0, 1, 0,   2'd1, 548, 16'h0000, 0);
        tbl[8]  = v(1, 0, 0, 0,   2'd1, 548, 16'h0000, 0);
        tbl[9]  = v(1, 0, 1, 0,   2'd1, 548, 16'h0000, 0);
        tbl[10] = v(1, 0, 0, 0,   2'd1, 547, 16'h0000, 0);
        tbl[11] = v(1, 1, 0, 0,   2'd1, 547, 16'h0000, 0);
        tbl[12] = v(1, 0, 0, 0,   2'd1, 547, 16'h0000, 0);
        tbl[13] = v(1, 0, 1, 0,   2'd1, 547, 16'h0000, 0);
        tbl[14] = v(1, 0, 0, 1,   2'd2, 547, 16'h0000, 1);
        tbl[15] = v(1, 0, 1, 0,   2'd2, 547, 16'h0000, 1);
        tbl[16] = v(1, 0, 0, 0,   2'd2, 547, 16'h0000, 1);
        tbl[17] = v(1, 1, 0, 0,   2'd1, 550, 16'h0000, 0);
        tbl[18] = v(1, 1, 0, 0,   2'd1, 550, 16'h0000, 0);
        tbl[19] = v(1, 0, 0, 1,   2'd2, 550, 16'h0000, 1);
        tbl[20] = v(1, 1, 0, 0,   2'd1, 550, 16'h0000, 0);
        tbl[21] = v(0, 1, 1, 0,   2'd0, 550, 16'h0000, 0);
        tbl[22] = v(1, 1, 1, 0,   2'd0, 550, 16'h0000, 0);
        tbl[23] = v(1, 1, 1, 0,   2'd0, 550, 16'h0000, 0);
        tbl[24] = v(1, 1, 1, 0,   2'd0, 550, 16'h0000, 0);
        tbl[25] = v(1, 0, 0, 1,   2'd0, 550, 16'h0000, 0);
        tbl[26] = v(1, 1, 0, 0,   2'd1, 550, 16'h0000, 0);

        for (int i = 0; i < 27; i++) begin
            reset = tbl[i].rst; start = tbl[i].st; frame_tick = tbl[i].tk; collision = tbl[i].co;
            @(posedge clk); #1;
            chk1($sformatf("vec%0d", i), tbl[i].e_state, tbl[i].e_x, 3'd1,
                 tbl[i].e_score, 16'h0000, tbl[i].e_go);
        end
        start = 1'b0; collision = 1'b0;

        // Fresh run from vec26: one point per 6 frames, 1 px per frame.
        frames(538); chk1("run538", 2'd1, 10'd12,  3'd1, 16'h0089, 16'h0000, 0);
        frames(1);   chk1("run539", 2'd1, 10'd11,  3'd1, 16'h0089, 16'h0000, 0);
        frames(1);   chk1("run540", 2'd1, 10'd550, 3'd1, 16'h0090, 16'h0000, 0);
        frames(59);  chk1("run599", 2'd1, 10'd491, 3'd1, 16'h0099, 16'h0000, 0);
        frames(1);   chk1("run600", 2'd1, 10'd490, 3'd2, 16'h0100, 16'h0000, 0);

        // Collision coincident with a frame pulse: no update, hi_score captured.
        frame_tick = 1'b1; @(posedge clk); #1;
        frame_tick = 1'b0; collision = 1'b1; @(posedge clk); #1;
        collision = 1'b0;
        chk1("coll_frame", 2'd2, 10'd490, 3'd2, 16'h0100, 16'h0100, 1);
        frames(2);   chk1("over_frozen", 2'd2, 10'd490, 3'd2, 16'h0100, 16'h0100, 1);

        // Start held for 10 cycles restarts exactly once.
        start = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        start = 1'b0;
        chk1("restart", 2'd1, 10'd550, 3'd1, 16'h0000, 16'h0100, 0);
        collision = 1'b1; @(posedge clk); #1; collision = 1'b0;
        chk1("low_score_over", 2'd2, 10'd550, 3'd1, 16'h0000, 16'h0100, 1);

        // Speed ramp and saturation on the one-frame-per-point instance.
        start2 = 1'b1; @(posedge clk); #1; start2 = 1'b0;
        chk2("f_start", 3'd1, 16'h0000);
        chk("f_start.cacti_x", 32'(x2), 32'd550);
        frames(99);   chk2("f_0099", 3'd1, 16'h0099);
        frames(1);    chk2("f_0100", 3'd2, 16'h0100);
        frames(399);  chk2("f_0499", 3'd5, 16'h0499);
        frames(1);    chk2("f_0500", 3'd6, 16'h0500);
        frames(99);   chk2("f_0599", 3'd6, 16'h0599);
        frames(1);    chk2("f_0600", 3'd6, 16'h0600);
        frames(9399); chk2("f_9999", 3'd6, 16'h9999);
        frames(2);    chk2("f_sat",  3'd6, 16'h9999);
        chk("f.hi_score", 32'(hi2), 32'd0);
        chk("f.game_over", 32'(go2), 32'd0);
        chk1("over_long", 2'd2, 10'd550, 3'd1, 16'h0000, 16'h0100, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
